deser_bitslip_align: RTL and testbench



---
 rtl/deser_bitslip_align_if.sv | 26 ++
 rtl/deser_bitslip_align.sv | 148 ++++++++++++++
 tb/tb_deser_bitslip_align.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/deser_bitslip_align_if.sv
// Parallel-word and alignment-status bundle between the alignment
// controller and its environment (ISERDES2 side plus pixel parser).
interface deser_bitslip_align_if #(
  parameter int DESER_WIDTH = 6
);
  logic                   i_align_en;
  logic [DESER_WIDTH-1:0] iv_data;
  logic                   o_bitslip;
  logic                   o_aligned;
  logic                   o_align_fail;
  logic [3:0]             ov_slip_cnt;
  logic [DESER_WIDTH-1:0] ov_data;
  logic                   o_data_valid;

  // Environment side: drives enable and raw word, observes status.
  modport master (
    output i_align_en, iv_data,
    input  o_bitslip, o_aligned, o_align_fail, ov_slip_cnt, ov_data, o_data_valid
  );

  // Controller side.
  modport slave (
    input  i_align_en, iv_data,
    output o_bitslip, o_aligned, o_align_fail, ov_slip_cnt, ov_data, o_data_valid
  );
endinterface

// File: rtl/deser_bitslip_align.sv
// Word-alignment controller for one deserialized LVDS channel.
// Compares the registered ISERDES2 word against a training pattern and
// issues single-cycle bitslip pulses until MATCH_NUM consecutive words
// match (lock) or MAX_SLIP rotations have been tried (failure).
module deser_bitslip_align #(
  parameter int                     DESER_WIDTH      = 6,
  parameter logic [DESER_WIDTH-1:0] TRAINING_PATTERN = 6'b111000,
  parameter int                     MATCH_NUM        = 16,
  parameter int                     SLIP_WAIT        = 3,
  parameter int                     MAX_SLIP         = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  deser_bitslip_align_if.slave     bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam logic [7:0] MATCH_LAST = 8'(MATCH_NUM - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);
  localparam logic [3:0] SLIP_MAX   = 4'(MAX_SLIP);

  state_t                 state_q;
  logic [DESER_WIDTH-1:0] data_q;
  logic [7:0]             match_cnt_q;
  logic [3:0]             wait_cnt_q;
  logic [3:0]             slip_cnt_q;
  logic                   bitslip_q;
  logic                   aligned_q;
  logic                   fail_q;
  logic                   pat_match_s;

  assign pat_match_s = (data_q == TRAINING_PATTERN);

  // Input register: every comparison and the forwarded word use this copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= bus.iv_data;
    end
  end

  // Alignment FSM with its counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= 8'd0;
      wait_cnt_q  <= 4'd0;
      slip_cnt_q  <= 4'd0;
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else if (!bus.i_align_en) begin
      // Dropping enable wins over any transition in the same cycle.
      state_q     <= ST_IDLE;
      match_cnt_q <= 8'd0;
      wait_cnt_q  <= 4'd0;
      slip_cnt_q  <= 4'd0;
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      // Bitslip is a pulse: only the CHECK->SLIP transition raises it.
      bitslip_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          match_cnt_q <= 8'd0;
          wait_cnt_q  <= 4'd0;
          slip_cnt_q  <= 4'd0;
          aligned_q   <= 1'b0;
          fail_q      <= 1'b0;
          state_q     <= ST_CHECK;
        end
        ST_CHECK: begin
          if (pat_match_s) begin
            match_cnt_q <= match_cnt_q + 8'd1;
            if (match_cnt_q == MATCH_LAST) begin
              state_q   <= ST_LOCKED;
              aligned_q <= 1'b1;
            end else begin
              state_q   <= ST_CHECK;
            end
          end else begin
            // Any mismatch restarts the run, even after partial matches.
            match_cnt_q <= 8'd0;
            if (slip_cnt_q == SLIP_MAX) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q   <= ST_SLIP;
              bitslip_q <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q < SLIP_MAX) begin
            slip_cnt_q <= slip_cnt_q + 4'd1;
          end else begin
            slip_cnt_q <= slip_cnt_q;
          end
          wait_cnt_q <= 4'd0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Words are ignored while the ISERDES2 output settles.
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q  <= 4'd0;
            match_cnt_q <= 8'd0;
            state_q     <= ST_CHECK;
          end else begin
            wait_cnt_q  <= wait_cnt_q + 4'd1;
            state_q     <= ST_WAIT;
          end
        end
        ST_LOCKED: begin
          state_q <= ST_LOCKED;
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q     <= ST_IDLE;
          match_cnt_q <= 8'd0;
          wait_cnt_q  <= 4'd0;
          slip_cnt_q  <= 4'd0;
          aligned_q   <= 1'b0;
          fail_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bitslip    = bitslip_q;
  assign bus.o_aligned    = aligned_q;
  assign bus.o_data_valid = aligned_q;
  assign bus.o_align_fail = fail_q;
  assign bus.ov_slip_cnt  = slip_cnt_q;
  assign bus.ov_data      = data_q;

endmodule

// File: tb/tb_deser_bitslip_align.sv
// Directed bench for deser_bitslip_align with a small ISERDES2 model that
// rotates the word left by one, two cycles after each bitslip pulse.
module tb_deser_bitslip_align;

  localparam logic [5:0] PAT = 6'b111000;

  logic clk;
  logic reset;

  deser_bitslip_align_if #(.DESER_WIDTH(6)) bus ();

  deser_bitslip_align #(
    .DESER_WIDTH      (6),
    .TRAINING_PATTERN (6'b111000),
    .MATCH_NUM        (16),
    .SLIP_WAIT        (3),
    .MAX_SLIP         (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ISERDES model state
  logic [5:0] word;
  logic [2:0] pipe;
  bit         rot_en;
  int         bad_k;

  // per-run observations
  int pcnt, p_first, p_last, p_gap, lock_t, fail_t;
  bit b2b, dv_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, model updated.
  task automatic tick();
    @(posedge clk);
    #1;
    pipe = {pipe[1:0], bus.o_bitslip};
    if (rot_en && pipe[2]) word = {word[4:0], word[5]};
  endtask

  // Enable sampled at the first edge of this run; n edges observed.
  task automatic run(input int n);
    pcnt = 0; p_first = 0; p_last = 0; p_gap = 1000;
    lock_t = 0; fail_t = 0; b2b = 1'b0; dv_bad = 1'b0;
    pipe = 3'b000;
    bus.iv_data    = word;
    bus.i_align_en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == bad_k) bus.iv_data = 6'b101010;
      else            bus.iv_data = word;
      if (bus.o_bitslip) begin
        pcnt++;
        if (p_last != 0 && p_last == k - 1) b2b = 1'b1;
        if (p_last != 0 && (k - p_last) < p_gap) p_gap = k - p_last;
        if (p_first == 0) p_first = k;
        p_last = k;
      end
      if (bus.o_aligned && lock_t == 0) lock_t = k;
      if (bus.o_align_fail && fail_t == 0) fail_t = k;
      if (bus.o_data_valid !== bus.o_aligned) dv_bad = 1'b1;
    end
  endtask

  task automatic disable_en();
    bus.i_align_en = 1'b0;
    tick();
  endtask

  // Matching data from the start: lock on the 17th edge, no slips.
  task automatic clean_lock(input string tag);
    word = PAT; rot_en = 1'b0; bad_k = -1;
    run(30);
    check({tag, "_lock_t"}, lock_t, 17);
    check({tag, "_pulses"}, pcnt, 0);
    check({tag, "_slip_cnt"}, bus.ov_slip_cnt, 0);
    check({tag, "_fail"}, fail_t, 0);
    check({tag, "_dv"}, dv_bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.i_align_en = 1'b0;
    bus.iv_data = 6'h2a;
    word = 6'h00; pipe = 3'b000; rot_en = 1'b0; bad_k = -1;
    tick(); tick();
    check("rst_bitslip", bus.o_bitslip, 0);
    check("rst_aligned", bus.o_aligned, 0);
    check("rst_fail",    bus.o_align_fail, 0);
    check("rst_dv",      bus.o_data_valid, 0);
    check("rst_slip",    bus.ov_slip_cnt, 0);
    check("rst_data",    bus.ov_data, 0);
    reset = 1'b0;

    // ov_data follows iv_data with one cycle latency
    bus.iv_data = 6'h15;
    tick();
    check("odata_a", bus.ov_data, 6'h15);
    bus.iv_data = 6'h2a;
    check("odata_hold", bus.ov_data, 6'h15);
    tick();
    check("odata_b", bus.ov_data, 6'h2a);

    // 1: aligned data from the start
    clean_lock("t1");
    disable_en();

    // 2: rotating model, offset 2 -> two slips, then lock
    word = 6'b001110; rot_en = 1'b1; bad_k = -1;
    run(40);
    check("t2_pulses",  pcnt, 2);
    check("t2_first",   p_first, 2);
    check("t2_last",    p_last, 7);
    check("t2_lock_t",  lock_t, 27);
    check("t2_slip",    bus.ov_slip_cnt, 2);
    check("t2_fail",    fail_t, 0);
    check("t2_b2b",     b2b, 0);
    disable_en();

    // 3: never matches -> six slips then failure
    word = 6'h00; rot_en = 1'b0; bad_k = -1;
    run(50);
    check("t3_pulses",  pcnt, 6);
    check("t3_first",   p_first, 2);
    check("t3_gap",     p_gap, 5);
    check("t3_last",    p_last, 27);
    check("t3_fail_t",  fail_t, 32);
    check("t3_lock",    lock_t, 0);
    check("t3_slip",    bus.ov_slip_cnt, 6);
    check("t3_b2b",     b2b, 0);
    disable_en();
    check("t3_fail_clr", bus.o_align_fail, 0);
    check("t3_slip_clr", bus.ov_slip_cnt, 0);

    // 4: ten good words, one corrupt, then good again (no rotation)
    word = PAT; rot_en = 1'b0; bad_k = 10;
    run(45);
    check("t4_pulses", pcnt, 1);
    check("t4_first",  p_first, 12);
    check("t4_lock_t", lock_t, 32);
    check("t4_slip",   bus.ov_slip_cnt, 1);
    check("t4_fail",   fail_t, 0);
    bad_k = -1;
    disable_en();

    // 5a: drop enable during WAIT
    word = 6'h00; rot_en = 1'b0;
    run(3);
    check("t5_slip_in_wait", bus.ov_slip_cnt, 1);
    check("t5_pulse_seen",   pcnt, 1);
    disable_en();
    check("t5w_bitslip", bus.o_bitslip, 0);
    check("t5w_aligned", bus.o_aligned, 0);
    check("t5w_fail",    bus.o_align_fail, 0);
    check("t5w_slip",    bus.ov_slip_cnt, 0);
    // 5b: restart, then drop enable while LOCKED
    clean_lock("t5r");
    check("t5r_locked", bus.o_aligned, 1);
    disable_en();
    check("t5l_aligned", bus.o_aligned, 0);
    check("t5l_dv",      bus.o_data_valid, 0);
    check("t5l_slip",    bus.ov_slip_cnt, 0);

    // 6: reset during the SLIP cycle
    word = 6'h01; rot_en = 1'b0;
    run(2);
    check("t6_in_slip", bus.o_bitslip, 1);
    reset = 1'b1;
    bus.i_align_en = 1'b0;
    tick();
    check("t6_bitslip", bus.o_bitslip, 0);
    check("t6_aligned", bus.o_aligned, 0);
    check("t6_fail",    bus.o_align_fail, 0);
    check("t6_slip",    bus.ov_slip_cnt, 0);
    check("t6_data",    bus.ov_data, 0);
    reset = 1'b0;
    tick();
    clean_lock("t6r");
    disable_en();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
